joy_db15_tx: RTL and testbench

Device-side counterpart of the DB15 serial joystick link. It emulates the adapter's parallel-load shift-register chain: it latches two players' button words on JOY_LOAD and serialises them on JOY_DATA, clocked by JOY_CLK from the host. It is used to feed USB/keyboard joystick state to an external MiSTer-style host, and as a loopback model against the DB15 receiver on the bench. All link inputs are asynchronous to clk_sys.

---
 rtl/joy_db15_if.sv | 10 +
 rtl/joy_db15_tx.sv | 75 +++++++
 tb/tb_joy_db15_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/joy_db15_if.sv
// DB15 joystick link pins: latch strobe and shift clock from the host,
// serial data back from the device.
interface joy_db15_if;
  logic JOY_LOAD;
  logic JOY_CLK;
  logic JOY_DATA;

  modport master (output JOY_LOAD, output JOY_CLK, input JOY_DATA);
  modport slave  (input JOY_LOAD, input JOY_CLK, output JOY_DATA);
endinterface

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial joystick link: emulates the adapter's
// parallel-load shift-register chain for two players.
module joy_db15_tx #(
  parameter int NBITS       = 12,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [NBITS-1:0] joystick1,
  input  logic [NBITS-1:0] joystick2,
  joy_db15_if.slave        link,
  output logic             frame_done,
  output logic [5:0]       bit_cnt
);

  localparam int         FRAME     = 2 * NBITS;
  localparam logic [5:0] FRAME_LEN = 6'(FRAME);
  localparam logic [5:0] LAST_BIT  = 6'(FRAME - 1);

  logic [SYNC_STAGES-1:0] load_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   clk_d;
  logic                   load_s;
  logic                   clk_s;
  logic                   clk_rise;
  logic [FRAME-1:0]       shreg;
  logic                   joy_data_q;

  // Idle levels are preset so that reset release never looks like a load
  // or a clock edge to the logic below.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_sync <= '1;
      clk_sync  <= '0;
      clk_d     <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], link.JOY_LOAD};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], link.JOY_CLK};
      clk_d     <= clk_s;
    end
  end

  assign load_s   = load_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;

  // Load has priority over a coincident clock edge; the chain shifts in 1s
  // (released) once both player words have gone out.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      joy_data_q <= 1'b1;
    end else begin
      joy_data_q <= shreg[0];
      frame_done <= 1'b0;
      if (!load_s) begin
        shreg   <= {~joystick2, ~joystick1};
        bit_cnt <= '0;
      end else if (clk_rise) begin
        shreg <= {1'b1, shreg[FRAME-1:1]};
        if (bit_cnt != FRAME_LEN) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
        frame_done <= (bit_cnt == LAST_BIT);
      end
    end
  end

  assign link.JOY_DATA = joy_data_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: expected wire bits are queued as the
// host clocks are driven and compared once the device output has settled.
module tb_joy_db15_tx;
  localparam int NBITS = 12;
  localparam int FRAME = 2 * NBITS;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic [NBITS-1:0] joystick1;
  logic [NBITS-1:0] joystick2;
  logic             frame_done;
  logic [5:0]       bit_cnt;

  joy_db15_if link ();

  joy_db15_tx #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .link      (link.slave),
    .frame_done(frame_done),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;

  always @(posedge clk_sys) if (frame_done === 1'b1) fd_cnt++;

  logic [FRAME-1:0] model_vec;
  int               model_idx;
  logic             exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic exp_bit(input int idx);
    return (idx < FRAME) ? model_vec[idx] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_cnt(input int idx);
    return (idx < FRAME) ? 32'(idx) : 32'(FRAME);
  endfunction

  task automatic pop_check(input string tag);
    logic e;
    check({tag, "_q"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, link.JOY_DATA, e);
    end
  endtask

  task automatic do_load(input logic [NBITS-1:0] j1, input logic [NBITS-1:0] j2, input int hold);
    joystick1     = j1;
    joystick2     = j2;
    link.JOY_LOAD = 1'b0;
    model_vec     = {~j2, ~j1};
    model_idx     = 0;
    exp_q.push_back(exp_bit(0));
    cycles(hold);
    link.JOY_LOAD = 1'b1;
    cycles(6);
    pop_check("load_bit0");
  endtask

  task automatic clk_pulse(input string tag);
    link.JOY_CLK = 1'b1;
    model_idx++;
    exp_q.push_back(exp_bit(model_idx));
    cycles(8);
    link.JOY_CLK = 1'b0;
    cycles(8);
    pop_check(tag);
    check({tag, "_cnt"}, 32'(bit_cnt), exp_cnt(model_idx));
  endtask

  initial begin
    int lat;
    int fd0;
    logic old;
    logic [5:0] cnt0;

    // Reset with LOAD held low: reset must dominate the load path.
    reset_n       = 1'b0;
    link.JOY_LOAD = 1'b0;
    link.JOY_CLK  = 1'b0;
    joystick1     = 12'hFFF;
    joystick2     = 12'h000;
    cycles(5);
    check("rst_data", link.JOY_DATA, 1'b1);
    check("rst_cnt", 32'(bit_cnt), 0);
    check("rst_fd", frame_done, 1'b0);
    link.JOY_LOAD = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
    check("idle_data", link.JOY_DATA, 1'b1);
    fd_cnt = 0;

    // Basic frame plus overrun.
    do_load(12'h005, 12'h800, 10);
    for (int i = 1; i <= FRAME; i++) begin
      if (i == FRAME) check("fd_before_last", fd_cnt, 0);
      clk_pulse($sformatf("frame_b%0d", i));
    end
    check("fd_once", fd_cnt, 1);
    for (int i = 0; i < 4; i++) clk_pulse($sformatf("overrun%0d", i));
    check("overrun_fd", fd_cnt, 1);

    // Mid-frame input change is ignored; mid-frame reload aborts the frame.
    do_load(12'h005, 12'h000, 10);
    joystick1 = 12'h000;
    for (int i = 0; i < 5; i++) clk_pulse($sformatf("mid_b%0d", i));
    fd0 = fd_cnt;
    joystick1     = 12'h001;
    link.JOY_LOAD = 1'b0;
    model_vec     = {~joystick2, ~joystick1};
    model_idx     = 0;
    cycles(5);
    check("reload_data", link.JOY_DATA, 1'b0);
    check("reload_cnt", 32'(bit_cnt), 0);
    link.JOY_LOAD = 1'b1;
    cycles(6);
    check("reload_fd", fd_cnt, fd0);
    clk_pulse("reload_b1");
    clk_pulse("reload_b2");

    // Load falling and clock rising together: load wins, no shift.
    joystick1     = 12'h003;
    model_vec     = {~joystick2, ~joystick1};
    model_idx     = 0;
    link.JOY_LOAD = 1'b0;
    link.JOY_CLK  = 1'b1;
    cycles(10);
    link.JOY_LOAD = 1'b1;
    cycles(8);
    link.JOY_CLK = 1'b0;
    cycles(8);
    check("coll_cnt", 32'(bit_cnt), 0);
    check("coll_data", link.JOY_DATA, exp_bit(0));
    clk_pulse("coll_b1");

    // Latency from a raw clock edge to the wire.
    do_load(12'h005, 12'h000, 10);
    old = link.JOY_DATA;
    link.JOY_CLK = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_sys);
      #1;
      lat++;
      if (link.JOY_DATA !== old) break;
    end
    check("latency", lat, 4);
    check("latency_bit", link.JOY_DATA, exp_bit(1));
    cycles(6);
    link.JOY_CLK = 1'b0;
    cycles(8);

    // One-cycle glitch: at most one shift.
    cnt0 = bit_cnt;
    link.JOY_CLK = 1'b1;
    cycles(1);
    link.JOY_CLK = 1'b0;
    cycles(8);
    check("glitch", 32'(bit_cnt - cnt0 <= 6'd1), 1);

    // Reset mid-frame while the wire shows a pressed bit.
    do_load(12'h005, 12'h000, 10);
    clk_pulse("prerst_b1");
    clk_pulse("prerst_b2");
    reset_n = 1'b0;
    #1;
    check("midrst_data", link.JOY_DATA, 1'b1);
    check("midrst_cnt", 32'(bit_cnt), 0);
    cycles(3);
    reset_n = 1'b1;
    cycles(10);
    check("postrst_data", link.JOY_DATA, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
